// File: rtl/debug_ram_pkg.sv
// Shared constants and types for the debug RAM write side and the display pipeline.
package debug_ram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int ROW_W  = 6;
  localparam int COL_W  = 4;

  typedef enum logic {IDLE, CLEAR} state_t;

  // RAM word address is row-major: {row, col}
  function automatic logic [ADDR_W-1:0] compose_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers who was served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr_reg=1 means r0 was served last, so r1 wins a tie
  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = ptr_reg ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_reg <= 1'b0;
    else if (accept) ptr_reg <= grant[0];
  end

endmodule

// File: rtl/debug_ram_wr_ctrl.sv
// Owns debug RAM port A: arbitrates two write requesters and runs a full-RAM clear sweep.
module debug_ram_wr_ctrl #(
  parameter int ADDR_W = debug_ram_pkg::ADDR_W,
  parameter int DATA_W = debug_ram_pkg::DATA_W,
  parameter int DEPTH  = debug_ram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              ram_en_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a
);

  import debug_ram_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t     state_reg;
  logic       active_reg;
  logic [1:0] grant;
  logic       arb_en;
  logic       accept;

  // Readies stay low during reset and the clear sweep; a clear request beats any write
  assign arb_en   = active_reg && (state_reg == IDLE) && !clear_start;
  assign accept   = |(grant & {r1_valid, r0_valid});
  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({r1_valid, r0_valid}),
    .enable (arb_en),
    .accept (accept),
    .grant  (grant)
  );

  // During CLEAR the address register is the sweep counter and the data register holds the fill value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      active_reg <= 1'b0;
      ram_en_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
      clear_busy <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      if (state_reg == IDLE) begin
        if (clear_start) begin
          state_reg  <= CLEAR;
          ram_en_a   <= 1'b1;
          ram_addr_a <= '0;
          ram_data_a <= clear_value;
          clear_busy <= 1'b1;
        end else if (accept) begin
          ram_en_a   <= 1'b1;
          ram_addr_a <= grant[1] ? r1_addr : r0_addr;
          ram_data_a <= grant[1] ? r1_data : r0_data;
        end else begin
          ram_en_a <= 1'b0;
        end
      end else begin
        if (ram_addr_a == LAST_ADDR) begin
          state_reg  <= IDLE;
          ram_en_a   <= 1'b0;
          clear_busy <= 1'b0;
        end else begin
          ram_addr_a <= ram_addr_a + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_ram_wr_ctrl.sv
// Self-checking bench: vector table for arbitration, scoreboard queue for RAM port A strobes.
module tb_debug_ram_wr_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  typedef struct {
    bit          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit          clr;
    logic [DW-1:0] cv;
    bit          e0;
    bit          e1;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ready, r1_ready;
  logic          ram_en_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;

  int  checks = 0;
  int  errors = 0;
  int  busy_cnt = 0;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  debug_ram_wr_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .r0_valid    (r0_valid),
    .r0_addr     (r0_addr),
    .r0_data     (r0_data),
    .r0_ready    (r0_ready),
    .r1_valid    (r1_valid),
    .r1_addr     (r1_addr),
    .r1_data     (r1_data),
    .r1_ready    (r1_ready),
    .ram_en_a    (ram_en_a),
    .ram_addr_a  (ram_addr_a),
    .ram_data_a  (ram_data_a)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && ram_en_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h, expected no strobe",
                 ram_addr_a, ram_data_a);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr_a), 32'(w.addr));
        check("wr_data", 32'(ram_data_a), 32'(w.data));
      end
    end
    if (clear_busy) busy_cnt++;
  end

  task automatic step(input vec_t v, input string name, input bit quiet);
    r0_valid    = v.v0;  r0_addr = v.a0;  r0_data = v.d0;
    r1_valid    = v.v1;  r1_addr = v.a1;  r1_data = v.d1;
    clear_start = v.clr; clear_value = v.cv;
    @(negedge clk); #1;
    check({name, "_r0_ready"}, 32'(r0_ready), 32'(v.e0));
    check({name, "_r1_ready"}, 32'(r1_ready), 32'(v.e1));
    if (v.e0) exp_q.push_back('{v.a0, v.d0});
    if (v.e1) exp_q.push_back('{v.a1, v.d1});
    if (!quiet && (v.e0 || v.e1))
      $display("%s: xfer r%0d addr 0x%03h data 0x%02h", name, v.e1 ? 1 : 0,
               v.e1 ? v.a1 : v.a0, v.e1 ? v.d1 : v.d0);
    @(posedge clk); #1;
    clear_start = 1'b0;
  endtask

  task automatic push_sweep(input logic [DW-1:0] val, input int last);
    for (int i = 0; i <= last; i++) exp_q.push_back('{AW'(i), val});
  endtask

  function automatic vec_t mk(input bit v0, input int a0, input int d0,
                              input bit v1, input int a1, input int d1,
                              input bit clr, input int cv, input bit e0, input bit e1);
    vec_t v;
    v.v0 = v0;  v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.v1 = v1;  v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.clr = clr; v.cv = DW'(cv); v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  initial begin
    vec_t idle_v, hold_v;
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Arbitration table; pointer starts on r0 after reset
    tbl[0]  = idle_v;
    tbl[1]  = mk(1, 'h001, 'h11, 1, 'h3F0, 'h21, 0, 0, 1, 0);
    tbl[2]  = mk(1, 'h002, 'h12, 1, 'h3F0, 'h21, 0, 0, 0, 1);
    tbl[3]  = mk(1, 'h002, 'h12, 1, 'h3F1, 'h22, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0,       1, 'h3F1, 'h22, 0, 0, 0, 1);
    tbl[5]  = idle_v;
    tbl[6]  = mk(1, 'h05A, 'hC3, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = idle_v;
    tbl[8]  = idle_v;
    tbl[9]  = mk(0, 0, 0,       1, 'h100, 'hAA, 0, 0, 0, 1);
    tbl[10] = mk(1, 'h200, 'h01, 1, 'h201, 'h02, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0,       1, 'h201, 'h02, 0, 0, 0, 1);

    // Reset with random inputs: every output low
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      r0_valid = 1'($urandom); r0_addr = AW'($urandom); r0_data = DW'($urandom);
      r1_valid = 1'($urandom); r1_addr = AW'($urandom); r1_data = DW'($urandom);
      clear_start = 1'($urandom); clear_value = DW'($urandom);
      @(negedge clk); #1;
      check("reset_outputs",
            32'({ram_en_a, ram_addr_a, ram_data_a, clear_busy, r0_ready, r1_ready}), 32'd0);
    end
    r0_valid = 0; r1_valid = 0; clear_start = 0;
    mon_en = 1'b1;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Full clear to 0x00 with an r1 write waiting behind it
    hold_v = mk(0, 0, 0, 1, 'h155, 'h5A, 0, 0, 0, 0);
    busy_cnt = 0;
    step(mk(0, 0, 0, 1, 'h155, 'h5A, 1, 'h00, 0, 0), "clr_start", 1'b0);
    push_sweep(8'h00, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) step(hold_v, "clr_wait", 1'b1);
    $display("clear sweep value 0x00 done, busy cycles %0d", busy_cnt);
    step(mk(0, 0, 0, 1, 'h155, 'h5A, 0, 0, 0, 1), "clr_after", 1'b0);
    check("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    step(idle_v, "drain", 1'b1);

    // clear_start collides with an r0 request: clear wins, r0 goes afterwards
    hold_v = mk(1, 'h3FF, 'h81, 0, 0, 0, 0, 0, 0, 0);
    busy_cnt = 0;
    step(mk(1, 'h3FF, 'h81, 0, 0, 0, 1, 'hA5, 0, 0), "col_start", 1'b0);
    push_sweep(8'hA5, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) step(hold_v, "col_wait", 1'b1);
    $display("collision sweep value 0xa5 done, busy cycles %0d", busy_cnt);
    step(mk(1, 'h3FF, 'h81, 0, 0, 0, 0, 0, 1, 0), "col_after", 1'b0);
    check("col_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    step(idle_v, "drain", 1'b1);

    // Reset in the middle of a sweep, while address 0x200 is on the port
    step(mk(0, 0, 0, 0, 0, 0, 1, 'h33, 0, 0), "mid_start", 1'b0);
    push_sweep(8'h33, 'h200);
    for (int i = 0; i < 'h200; i++) step(idle_v, "mid_wait", 1'b1);
    @(negedge clk); #1;
    check("mid_sweep_addr", 32'(ram_addr_a), 32'h200);
    rst_n = 1'b0;
    #1;
    check("mid_reset_en", 32'(ram_en_a), 32'd0);
    check("mid_reset_busy", 32'(clear_busy), 32'd0);
    $display("reset asserted mid-sweep");
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Pointer favoured r1 before the reset; after it r0 must win the tie
    step(mk(1, 'h0AB, 'h01, 1, 'h0CD, 'h02, 0, 0, 1, 0), "post_reset", 1'b0);
    step(idle_v, "drain", 1'b1);
    step(idle_v, "drain", 1'b1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_ram_wr_ctrl.md
Name: debug_ram_wr_ctrl

Overview:
- Owns write port A of the 1024x8 debug RAM. Port B stays with the VGA debug-display pipeline.
- Shares port A between two write requesters using round-robin arbitration with valid/ready handshakes.
- Provides a clear engine that fills the whole RAM with a constant value.
- Sits between producer blocks (CA engine, loader) and the `my_ram2` port A pins (`en_a`, `addr_a`, `data_in_a`). It runs on the pixel clock domain `clk`.

Parameters:
- ADDR_W, 10, RAM address width; address is {row[5:0], col[3:0]}.
- DATA_W, 8, RAM data width.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.

Ports:
- clk  in  1  pixel clock; same clock drives RAM port A.
- rst_n  in  1  asynchronous reset, active low.
- clear_start  in  1  single-cycle pulse; requests a full-RAM fill.
- clear_value  in  DATA_W  fill value, sampled together with clear_start.
- clear_busy  out  1  high while the fill sweep is running.
- r0_valid  in  1  requester 0 has a write pending.
- r0_addr  in  ADDR_W  requester 0 write address.
- r0_data  in  DATA_W  requester 0 write data.
- r0_ready  out  1  requester 0 write accepted this cycle.
- r1_valid, r1_addr, r1_data, r1_ready: same as requester 0, for requester 1.
- ram_en_a  out  1  RAM port A write strobe.
- ram_addr_a  out  ADDR_W  RAM port A address.
- ram_data_a  out  DATA_W  RAM port A write data.

Behaviour:
- Reset (async, rst_n=0):
  - ram_en_a=0, ram_addr_a=0, ram_data_a=0, clear_busy=0, r0_ready=0, r1_ready=0.
  - State=IDLE; round-robin pointer selects r0 first.
  - Asserting reset mid-sweep abandons the sweep. No write strobe is issued after reset asserts.
- States: IDLE, CLEAR.
- IDLE:
  - If clear_start=1: latch clear_value, reset the sweep counter to 0, go to CLEAR.
  - Both ready outputs are forced low in that cycle; clear_start has priority over requests.
  - Otherwise arbitrate:
    - Only one valid: that requester is granted.
    - Both valid: the requester not served last is granted.
  - rN_ready is combinational from valid, state, clear_start and the pointer. At most one ready is high per cycle.
  - A transfer occurs on a rising edge with valid&ready. The pointer toggles only on a transfer.
- Write latency: the cycle after a transfer, ram_en_a=1 with the registered addr/data of the granted request, for exactly one cycle unless another transfer follows.
  - Back-to-back transfers give continuous strobes at one write per cycle.
- CLEAR:
  - Each cycle: ram_en_a=1, ram_addr_a=counter, ram_data_a=latched value; counter increments.
  - Sweep runs 0..DEPTH-1 (DEPTH cycles). The counter is ADDR_W wide and terminates at all-ones with no wrap write.
  - clear_busy is high for exactly the DEPTH strobe cycles.
  - r0_ready and r1_ready stay low throughout. clear_start is ignored during CLEAR.
  - After the address DEPTH-1 cycle, return to IDLE. The pointer is unchanged by a clear.
- Requester rule: addr/data must be held stable while valid=1 and ready=0. valid is never revoked before acceptance.
- No read path: RAM port A data out is unused.

Decomposition:
- Package debug_ram_pkg holds:
  - ADDR_W, DATA_W, DEPTH, ROW_W=6, COL_W=4.
  - The state enum {IDLE, CLEAR}.
  - An address-compose helper {row, col}, shared with the display pipeline.
- One sub-module, rr_arb2: a two-way round-robin grant with a pointer register that updates on an accept signal.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. After release, with no valid and no clear, ram_en_a stays 0.
- Single write: r0_valid with addr 0x05A, data 0xC3 -> r0_ready=1 in the same cycle. Next cycle ram_en_a=1, addr 0x05A, data 0xC3; the cycle after, ram_en_a=0.
- Contention: r0 and r1 both valid for 4 transfers (r0 addrs 0x001/0x002, r1 addrs 0x3F0/0x3F1) -> grants r0, r1, r0, r1; ram_en_a high on 4 consecutive cycles in that address order.
- Clear sweep: clear_start with value 0x00 -> clear_busy high for exactly 1024 cycles; ram_addr_a 0,1,...,1023 with data 0x00; readies low. A pending r1 write is accepted on the first IDLE cycle after.
- Collision: clear_start in the same cycle as r0_valid -> r0_ready=0; the sweep runs 1024 cycles; r0 is then accepted and writes its data.
- Mid-sweep reset: assert rst_n=0 when ram_addr_a=0x200 -> ram_en_a=0 and clear_busy=0 immediately. After release the block is in IDLE with the pointer on r0.
